// File: rtl/fast_core_pkg.sv
// Shared definitions for the fetch-return alignment path: MCS-51 opcode
// length table and the fixed fetch chunk size.
package fast_core_pkg;

  localparam int INSTR_BYTES = 3;

  typedef logic [255:0][1:0] op_table_t;

  // Length decode organised by opcode column (low nibble), then row (high nibble).
  function automatic logic [1:0] calc_op_length(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] len;
    hi  = op[7:4];
    lo  = op[3:0];
    len = 2'd1;
    case (lo)
      4'h0: case (hi)
              4'h1, 4'h2, 4'h3, 4'h9:                      len = 2'd3;
              4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB,
              4'hC, 4'hD:                                  len = 2'd2;
              default:                                     len = 2'd1;
            endcase
      4'h1: len = 2'd2;
      4'h2: case (hi)
              4'h0, 4'h1:                                  len = 2'd3;
              4'h2, 4'h3, 4'hE, 4'hF:                      len = 2'd1;
              default:                                     len = 2'd2;
            endcase
      4'h3: case (hi)
              4'h4, 4'h5, 4'h6:                            len = 2'd3;
              default:                                     len = 2'd1;
            endcase
      4'h4: case (hi)
              4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9:    len = 2'd2;
              4'hB:                                        len = 2'd3;
              default:                                     len = 2'd1;
            endcase
      4'h5: case (hi)
              4'h7, 4'h8, 4'hB, 4'hD:                      len = 2'd3;
              4'hA:                                        len = 2'd1;
              default:                                     len = 2'd2;
            endcase
      4'h6, 4'h7: case (hi)
              4'h7, 4'h8, 4'hA:                            len = 2'd2;
              4'hB:                                        len = 2'd3;
              default:                                     len = 2'd1;
            endcase
      default: case (hi)
              4'h7, 4'h8, 4'hA, 4'hD:                      len = 2'd2;
              4'hB:                                        len = 2'd3;
              default:                                     len = 2'd1;
            endcase
    endcase
    return len;
  endfunction

  function automatic op_table_t build_op_length_table();
    op_table_t t;
    for (int i = 0; i < 256; i++) begin
      t[i] = calc_op_length(8'(i));
    end
    return t;
  endfunction

  localparam op_table_t OP_LENGTH_TABLE = build_op_length_table();

  function automatic logic [1:0] op_length(input logic [7:0] op);
    return OP_LENGTH_TABLE[op];
  endfunction

endpackage

// File: rtl/fast_core_op_length.sv
// Combinational opcode-to-length ROM used by the head-of-window decode.
module fast_core_op_length
  import fast_core_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] length
);

  assign length = op_length(opcode);

endmodule

// File: rtl/fast_core_i_align.sv
// Fetch return alignment: orders A/B code-memory returns into a byte window
// and presents one left-aligned instruction per cycle to decode.
module fast_core_i_align
  import fast_core_pkg::*;
#(
  parameter int PC_BITWIDTH = 16,
  parameter int BUF_BYTES   = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   redirect,
  input  logic [PC_BITWIDTH-1:0] PC,
  input  logic                   re_A,
  input  logic                   re_B,
  input  logic [PC_BITWIDTH-1:0] fetch_addr_A,
  input  logic [PC_BITWIDTH-1:0] fetch_addr_B,
  input  logic [23:0]            data_A,
  input  logic [23:0]            data_B,
  input  logic                   ctl_instruction_consume,
  output logic [23:0]            current_instruction,
  output logic                   instruction_valid,
  output logic [1:0]             instruction_length,
  output logic [PC_BITWIDTH-1:0] instruction_PC,
  output logic [1:0]             addr_adjust,
  output logic [7:0]             drop_count
);

  localparam int                     CNT_W      = $clog2(BUF_BYTES + 1);
  localparam int                     WIN_W      = BUF_BYTES * 8;
  localparam logic [CNT_W-1:0]       BUF_CNT    = CNT_W'(BUF_BYTES);
  localparam logic [CNT_W-1:0]       CHUNK_CNT  = CNT_W'(INSTR_BYTES);
  localparam logic [PC_BITWIDTH-1:0] CHUNK_ADDR = PC_BITWIDTH'(INSTR_BYTES);

  // Byte i of the window lives at window[8*i +: 8]; byte 0 is the oldest.
  logic [WIN_W-1:0]       window, window_next;
  logic [CNT_W-1:0]       byte_count, kept, space, space_after_b, append_count, count_next;
  logic [PC_BITWIDTH-1:0] fill_addr, fill_after_b, fill_next;
  logic [PC_BITWIDTH-1:0] pend_addr_A, pend_addr_B;
  logic                   pend_A, pend_B;
  logic [1:0]             head_len, consumed;
  logic                   head_valid, flush;
  logic                   take_a, take_b, drop_a, drop_b;
  logic [47:0]            append_bytes;
  logic [8:0]             drop_sum;

  fast_core_op_length u_op_length (
    .opcode (window[7:0]),
    .length (head_len)
  );

  function automatic logic [23:0] to_window_order(input logic [23:0] d);
    return {d[7:0], d[15:8], d[23:16]};
  endfunction

  assign flush      = sync_reset | redirect;
  assign head_valid = (byte_count != '0) && (byte_count >= CNT_W'(head_len));
  // A flush discards the window, so nothing is reported as consumed that cycle.
  assign consumed   = (head_valid && ctl_instruction_consume && !flush) ? head_len : 2'd0;

  always_comb begin
    kept          = byte_count - CNT_W'(consumed);
    space         = BUF_CNT - kept;
    take_b        = pend_B && (pend_addr_B == fill_addr) && (space >= CHUNK_CNT);
    drop_b        = pend_B && (pend_addr_B != fill_addr);
    fill_after_b  = take_b ? fill_addr + CHUNK_ADDR : fill_addr;
    space_after_b = take_b ? space - CHUNK_CNT : space;
    take_a        = pend_A && (pend_addr_A == fill_after_b) && (space_after_b >= CHUNK_CNT);
    drop_a        = pend_A && (pend_addr_A != fill_after_b);
    fill_next     = take_a ? fill_after_b + CHUNK_ADDR : fill_after_b;

    append_bytes = '0;
    append_count = '0;
    case ({take_b, take_a})
      2'b11: begin
        append_bytes = {to_window_order(data_A), to_window_order(data_B)};
        append_count = CHUNK_CNT + CHUNK_CNT;
      end
      2'b10: begin
        append_bytes = {24'h0, to_window_order(data_B)};
        append_count = CHUNK_CNT;
      end
      2'b01: begin
        append_bytes = {24'h0, to_window_order(data_A)};
        append_count = CHUNK_CNT;
      end
      default: ;
    endcase
    count_next = kept + append_count;

    // Shift out consumed bytes, mask stale bytes past the survivors, land new bytes after them.
    window_next = ((window >> {consumed, 3'b000}) & ~({WIN_W{1'b1}} << {kept, 3'b000}))
                | (WIN_W'(append_bytes) << {kept, 3'b000});

    drop_sum = {1'b0, drop_count} + 9'(drop_a) + 9'(drop_b);
  end

  assign instruction_valid   = head_valid;
  assign instruction_length  = head_valid ? head_len : 2'd0;
  assign addr_adjust         = consumed;
  assign current_instruction = head_valid ?
                               {window[7:0],
                                (head_len >= 2'd2) ? window[15:8]  : 8'h00,
                                (head_len == 2'd3) ? window[23:16] : 8'h00} : 24'h0;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window         <= '0;
      byte_count     <= '0;
      fill_addr      <= '0;
      instruction_PC <= '0;
      pend_A         <= 1'b0;
      pend_B         <= 1'b0;
      pend_addr_A    <= '0;
      pend_addr_B    <= '0;
      drop_count     <= '0;
    end else begin
      pend_addr_A <= fetch_addr_A;
      pend_addr_B <= fetch_addr_B;
      if (flush) begin
        byte_count     <= '0;
        fill_addr      <= PC;
        instruction_PC <= PC;
        pend_A         <= 1'b0;
        pend_B         <= 1'b0;
        if (sync_reset) drop_count <= '0;
      end else begin
        pend_A         <= re_A;
        pend_B         <= re_B;
        window         <= window_next;
        byte_count     <= count_next;
        fill_addr      <= fill_next;
        instruction_PC <= instruction_PC + PC_BITWIDTH'(consumed);
        drop_count     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
    end
  end

endmodule

// File: tb/tb_fast_core_i_align.sv
// Directed bench for fast_core_i_align: ordering, length decode, drops,
// full-window back-pressure, flush and asynchronous reset.
module tb_fast_core_i_align;

  logic        clk;
  logic        reset_n;
  logic        sync_reset;
  logic        redirect;
  logic [15:0] PC;
  logic        re_A, re_B;
  logic [15:0] fetch_addr_A, fetch_addr_B;
  logic [23:0] data_A, data_B;
  logic        ctl_instruction_consume;
  logic [23:0] current_instruction;
  logic        instruction_valid;
  logic [1:0]  instruction_length;
  logic [15:0] instruction_PC;
  logic [1:0]  addr_adjust;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_errors = 0;

  fast_core_i_align #(.PC_BITWIDTH(16), .BUF_BYTES(9)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .sync_reset              (sync_reset),
    .redirect                (redirect),
    .PC                      (PC),
    .re_A                    (re_A),
    .re_B                    (re_B),
    .fetch_addr_A            (fetch_addr_A),
    .fetch_addr_B            (fetch_addr_B),
    .data_A                  (data_A),
    .data_B                  (data_B),
    .ctl_instruction_consume (ctl_instruction_consume),
    .current_instruction     (current_instruction),
    .instruction_valid       (instruction_valid),
    .instruction_length      (instruction_length),
    .instruction_PC          (instruction_PC),
    .addr_adjust             (addr_adjust),
    .drop_count              (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sync_reset = 1'b0;
    redirect   = 1'b0;
    re_A       = 1'b0;
    re_B       = 1'b0;
    ctl_instruction_consume = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic valid, input logic [23:0] instr,
                            input logic [1:0] len, input logic [15:0] ipc);
    check({tag, "_valid"}, 32'(instruction_valid), 32'(valid));
    check({tag, "_instr"}, 32'(current_instruction), 32'(instr));
    check({tag, "_len"}, 32'(instruction_length), 32'(len));
    check({tag, "_pc"}, 32'(instruction_PC), 32'(ipc));
  endtask

  task automatic issue(input logic b, input logic [15:0] addr_b, input logic a, input logic [15:0] addr_a);
    re_B = b; fetch_addr_B = addr_b;
    re_A = a; fetch_addr_A = addr_a;
  endtask

  initial begin
    reset_n = 1'b0;
    PC = '0; fetch_addr_A = '0; fetch_addr_B = '0; data_A = '0; data_B = '0;
    idle_inputs();
    #12;
    check_head("rst", 1'b0, 24'h0, 2'd0, 16'h0);
    check("rst_adj", 32'(addr_adjust), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Ordered A/B returns, LJMP at head.
    redirect = 1'b1; PC = 16'h0100;
    tick();
    idle_inputs();
    issue(1'b1, 16'h0100, 1'b1, 16'h0103);
    tick();
    issue(1'b0, 16'h0, 1'b0, 16'h0);
    data_B = 24'h020456; data_A = 24'h00E4FF;
    #1 check("t1_not_yet", 32'(instruction_valid), 32'd0);
    tick();
    check_head("t1_ljmp", 1'b1, 24'h020456, 2'd3, 16'h0100);
    ctl_instruction_consume = 1'b1;
    #1 check("t1_adj", 32'(addr_adjust), 32'd3);
    tick();
    ctl_instruction_consume = 1'b0;
    check_head("t1_nop", 1'b1, 24'h000000, 2'd1, 16'h0103);

    // Stream NOP / MOV A,#55 / INC A with consume held high.
    redirect = 1'b1; PC = 16'h0200;
    tick();
    idle_inputs();
    issue(1'b1, 16'h0200, 1'b1, 16'h0203);
    tick();
    issue(1'b0, 16'h0, 1'b0, 16'h0);
    data_B = 24'h007455; data_A = 24'h040000;
    tick();
    ctl_instruction_consume = 1'b1;
    #1;
    check_head("t2_c0", 1'b1, 24'h000000, 2'd1, 16'h0200);
    check("t2_c0_adj", 32'(addr_adjust), 32'd1);
    tick();
    check_head("t2_c1", 1'b1, 24'h745500, 2'd2, 16'h0201);
    check("t2_c1_adj", 32'(addr_adjust), 32'd2);
    tick();
    check_head("t2_c2", 1'b1, 24'h040000, 2'd1, 16'h0203);
    check("t2_c2_adj", 32'(addr_adjust), 32'd1);
    tick();
    ctl_instruction_consume = 1'b0;
    check("t2_pc_end", 32'(instruction_PC), 32'h0204);

    // Out-of-order drop, then fill to capacity with consume low.
    redirect = 1'b1; PC = 16'h0100;
    tick();
    idle_inputs();
    issue(1'b1, 16'h0100, 1'b1, 16'h0103);
    tick();
    issue(1'b0, 16'h0, 1'b1, 16'h0109);
    data_B = 24'h745500; data_A = 24'h000000;
    tick();
    check("t3_count6", 32'(dut.byte_count), 32'd6);
    issue(1'b1, 16'h0106, 1'b0, 16'h0);
    data_A = 24'hAABBCC;
    tick();
    check("t3_drop", 32'(drop_count), 32'd1);
    check("t3_count_kept", 32'(dut.byte_count), 32'd6);
    issue(1'b0, 16'h0, 1'b1, 16'h0109);
    data_B = 24'h000000;
    tick();
    check("t4_count9", 32'(dut.byte_count), 32'd9);
    issue(1'b1, 16'h0109, 1'b0, 16'h0);
    data_A = 24'h111111;
    tick();
    check("t4_full_count", 32'(dut.byte_count), 32'd9);
    check("t4_full_drop", 32'(drop_count), 32'd1);
    issue(1'b0, 16'h0, 1'b0, 16'h0);
    data_B = 24'h222222;
    ctl_instruction_consume = 1'b1;
    #1;
    check_head("t4_head", 1'b1, 24'h745500, 2'd2, 16'h0100);
    check("t4_adj", 32'(addr_adjust), 32'd2);
    tick();
    ctl_instruction_consume = 1'b0;
    check("t4_count7", 32'(dut.byte_count), 32'd7);
    check("t4_pc", 32'(instruction_PC), 32'h0102);
    check("t4_drop_same", 32'(drop_count), 32'd1);

    // Redirect with a matching return in flight.
    issue(1'b1, 16'h0109, 1'b0, 16'h0);
    tick();
    issue(1'b0, 16'h0, 1'b0, 16'h0);
    data_B = 24'h333333;
    redirect = 1'b1; PC = 16'h0300;
    tick();
    redirect = 1'b0;
    check("t5_count", 32'(dut.byte_count), 32'd0);
    check_head("t5_flushed", 1'b0, 24'h0, 2'd0, 16'h0300);
    check("t5_drop_kept", 32'(drop_count), 32'd1);
    ctl_instruction_consume = 1'b1;
    #1 check("t5_adj_invalid", 32'(addr_adjust), 32'd0);
    tick();
    ctl_instruction_consume = 1'b0;
    check("t5_pc_hold", 32'(instruction_PC), 32'h0300);

    // sync_reset clears drop_count.
    sync_reset = 1'b1; PC = 16'h0400;
    tick();
    sync_reset = 1'b0;
    check("t6_drop_clr", 32'(drop_count), 32'd0);
    check("t6_pc", 32'(instruction_PC), 32'h0400);

    // Asynchronous reset between clock edges.
    issue(1'b1, 16'h0400, 1'b1, 16'h0500);
    tick();
    issue(1'b0, 16'h0, 1'b0, 16'h0);
    data_B = 24'h020456; data_A = 24'h999999;
    tick();
    check("t7_drop", 32'(drop_count), 32'd1);
    ctl_instruction_consume = 1'b1;
    #1;
    check_head("t7_pre", 1'b1, 24'h020456, 2'd3, 16'h0400);
    #1 reset_n = 1'b0;
    #1;
    check_head("t7_async", 1'b0, 24'h0, 2'd0, 16'h0);
    check("t7_async_adj", 32'(addr_adjust), 32'd0);
    check("t7_async_drop", 32'(drop_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
